// File: rtl/if_pc_stage.sv
// Fetch-side next-PC selection and IF/ID pipeline register.
// Redirects (jr > branch > jump) squash the wrong-path word and bump a saturating counter.
module if_pc_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             c_jump,
  input  logic [15:0]      br_imm,
  input  logic             jump,
  input  logic [25:0]      jump_idx,
  input  logic             jr,
  input  logic [31:0]      jr_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc_out,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic [CNT_W-1:0] redirect_cnt
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] seq_pc;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] redirect_tgt;
  logic        req;

  assign seq_pc = pc_q + 32'd4;
  assign br_tgt = pc4_q + {{14{br_imm[15]}}, br_imm, 2'b00};
  assign j_tgt  = {pc4_q[31:28], jump_idx, 2'b00};

  // A bubble in IF/ID carries no decoded control flow, so it cannot redirect.
  assign req = valid_q & (jr | c_jump | jump);

  always_comb begin
    redirect_tgt = j_tgt;
    if (jr) begin
      redirect_tgt = jr_addr;
    end else if (c_jump) begin
      redirect_tgt = br_tgt;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      if (req) begin
        pc_d    = redirect_tgt;
        instr_d = 32'd0;
        valid_d = 1'b0;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        pc_d    = seq_pc;
        instr_d = imem_rdata;
        pc4_d   = seq_pc;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_out       = pc_q;
  assign ifid_instr   = instr_q;
  assign ifid_pc4     = pc4_q;
  assign ifid_valid   = valid_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_if_pc_stage.sv
// Bench for if_pc_stage: a cycle model of the fetch rules checked every cycle,
// plus hand-computed literal checks; a second instance with CNT_W=2 exercises saturation.
module tb_if_pc_stage;

  localparam logic [31:0] K = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst, stall, c_jump, jump, jr;
  logic [15:0] br_imm;
  logic [25:0] jump_idx;
  logic [31:0] jr_addr;

  logic [31:0] pc_a, instr_a, pc4_a, pc_b, instr_b, pc4_b;
  logic        valid_a, valid_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  logic [31:0] imem_a, imem_b;

  int checks = 0;
  int failures = 0;

  // Combinational instruction memory: word content is a simple function of address.
  assign imem_a = pc_a ^ K;
  assign imem_b = pc_b ^ K;

  always #5 clk = ~clk;

  if_pc_stage #(.RESET_PC(32'h0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .c_jump(c_jump), .br_imm(br_imm),
    .jump(jump), .jump_idx(jump_idx), .jr(jr), .jr_addr(jr_addr),
    .imem_rdata(imem_a), .pc_out(pc_a), .ifid_instr(instr_a), .ifid_pc4(pc4_a),
    .ifid_valid(valid_a), .redirect_cnt(cnt_a)
  );

  if_pc_stage #(.RESET_PC(32'h0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .c_jump(c_jump), .br_imm(br_imm),
    .jump(jump), .jump_idx(jump_idx), .jr(jr), .jr_addr(jr_addr),
    .imem_rdata(imem_b), .pc_out(pc_b), .ifid_instr(instr_b), .ifid_pc4(pc4_b),
    .ifid_valid(valid_b), .redirect_cnt(cnt_b)
  );

  // Reference model
  bit          m_known = 1'b0;
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_valid;
  int          m_redirects;

  always @(posedge clk) begin
    int off;
    if (rst) begin
      m_known = 1'b1;
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_redirects = 0;
    end else if (m_known && !stall) begin
      if (m_valid && (jr || c_jump || jump)) begin
        if (jr) begin
          m_pc = jr_addr;
        end else if (c_jump) begin
          off = $signed(br_imm);
          m_pc = m_pc4 + 32'(off * 4);
        end else begin
          m_pc = (m_pc4 & 32'hF000_0000) | (32'(jump_idx) * 32'd4);
        end
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_redirects++;
      end else begin
        m_instr = m_pc ^ K;
        m_pc4 = m_pc + 32'd4;
        m_pc = m_pc + 32'd4;
        m_valid = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_known) begin
      chk("model_pc", pc_a, m_pc);
      chk("model_valid", 32'(valid_a), 32'(m_valid));
      chk("model_instr", instr_a, m_instr);
      if (m_valid) chk("model_pc4", pc4_a, m_pc4);
      chk("model_cnt16", 32'(cnt_a), (m_redirects > 65535) ? 32'd65535 : 32'(m_redirects));
      chk("model_cnt2", 32'(cnt_b), (m_redirects > 3) ? 32'd3 : 32'(m_redirects));
      chk("model_pc_b", pc_b, m_pc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    stall = 0; c_jump = 0; jump = 0; jr = 0;
  endtask

  initial begin
    rst = 1; idle(); br_imm = '0; jump_idx = '0; jr_addr = '0;
    @(negedge clk);
    tick(2);
    rst = 0;
    chk("rst_pc", pc_a, 32'h0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);

    tick(1);
    chk("seq_pc4", pc_a, 32'h4);
    chk("seq_valid", 32'(valid_a), 32'd1);
    chk("seq_ifid_pc4", pc4_a, 32'h4);
    tick(3);
    chk("seq_pc16", pc_a, 32'h10);
    chk("seq_instr", instr_a, 32'hC ^ K);

    // Taken branch back from ifid_pc4=0x10 by -4 words.
    c_jump = 1; br_imm = 16'hFFFC;
    tick(1);
    c_jump = 0;
    chk("br_pc", pc_a, 32'h0);
    chk("br_valid", 32'(valid_a), 32'd0);
    chk("br_cnt", 32'(cnt_a), 32'd1);

    // Stall holds a pending branch, which then fires exactly once.
    tick(1);
    stall = 1; c_jump = 1; br_imm = 16'h0002;
    tick(3);
    chk("stall_pc", pc_a, 32'h4);
    chk("stall_pc4", pc4_a, 32'h4);
    chk("stall_cnt", 32'(cnt_a), 32'd1);
    stall = 0;
    tick(1);
    chk("unstall_pc", pc_a, 32'hC);
    chk("unstall_cnt", 32'(cnt_a), 32'd2);
    // c_jump still high while IF/ID holds a bubble: ignored.
    tick(1);
    c_jump = 0;
    chk("bubble_pc", pc_a, 32'h10);
    chk("bubble_cnt", 32'(cnt_a), 32'd2);

    // All three requests together: jr wins.
    jr = 1; jr_addr = 32'h400; c_jump = 1; jump = 1; jump_idx = 26'd5;
    tick(1);
    idle();
    chk("prio_pc", pc_a, 32'h400);
    tick(1);
    jr = 1; jr_addr = 32'hA000_000C;
    tick(1);
    idle();
    tick(1);
    chk("jmp_ifid_pc4", pc4_a, 32'hA000_0010);
    jump = 1; jump_idx = 26'd1;
    tick(1);
    idle();
    chk("jmp_pc", pc_a, 32'hA000_0004);
    chk("sat_cnt16", 32'(cnt_a), 32'd5);
    chk("sat_cnt2", 32'(cnt_b), 32'd3);

    // Unaligned jr target passes through untouched.
    tick(1);
    jr = 1; jr_addr = 32'h0000_0103;
    tick(1);
    idle();
    chk("jr_lowbits", pc_a, 32'h103);

    // PC wraps past the top of the address space.
    tick(1);
    jr = 1; jr_addr = 32'hFFFF_FFF8;
    tick(1);
    idle();
    tick(2);
    chk("wrap_pc", pc_a, 32'h0);
    chk("wrap_ifid_pc4", pc4_a, 32'h0);

    // Reset during a stall clears everything.
    stall = 1;
    tick(2);
    rst = 1;
    tick(1);
    rst = 0; stall = 0;
    chk("rst2_pc", pc_a, 32'h0);
    chk("rst2_valid", 32'(valid_a), 32'd0);
    chk("rst2_instr", instr_a, 32'h0);
    chk("rst2_cnt", 32'(cnt_a), 32'd0);
    tick(2);
    chk("rst2_seq", pc_a, 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
